// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: opcode encodings and FSM state type.
package branch_resolver_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_BEQ = 2'b00;
  localparam logic [OP_W-1:0] OP_BNE = 2'b01;
  localparam logic [OP_W-1:0] OP_BLT = 2'b10;
  localparam logic [OP_W-1:0] OP_BGE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation.
// Ports: op (branch opcode), a, b (WIDTH operands); taken_c (condition true, combinational).
module branch_cond
  import branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             taken_c
);

  logic neq_c;
  logic lt_c;

  isNotEqual #(.WIDTH(WIDTH)) u_neq (
    .a     (a),
    .b     (b),
    .neq_c (neq_c)
  );

  // Signed compare: operands are two's complement register values.
  assign lt_c = ($signed(a) < $signed(b));

  // Opcode select of the condition.
  always_comb begin
    taken_c = 1'b0;
    case (op)
      OP_BEQ:  taken_c = !neq_c;
      OP_BNE:  taken_c = neq_c;
      OP_BLT:  taken_c = lt_c;
      OP_BGE:  taken_c = !lt_c;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/isNotEqual.sv
// Operand inequality detector shared with the ALU comparators.
// Ports: a, b (WIDTH operands); neq_c (1 when a != b, combinational).
module isNotEqual #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             neq_c
);

  assign neq_c = (a != b);

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one branch request, evaluates it, holds the resolved
// next PC until consumed, and keeps a saturating count of taken branches.
// Ports: clk, rst_n; in_valid/in_ready + in_op/in_a/in_b/in_target/in_pc_next
// (request); out_valid/out_ready + out_taken/out_pc (result);
// clr_count (synchronous counter clear); taken_count (saturating taken count).
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] in_pc_next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_pc,
  input  logic             clr_count,
  output logic [CNT_W-1:0] taken_count
);

  state_t           state;
  state_t           state_nxt;
  logic             accept_c;
  logic             eval_c;
  logic             taken_c;

  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] pc_next_q;

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .taken_c (taken_c)
  );

  // State register plus registered result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == RESP);
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept_c  = 1'b0;
    eval_c    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        eval_c    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_BEQ;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      pc_next_q <= '0;
    end else if (accept_c) begin
      op_q      <= in_op;
      a_q       <= in_a;
      b_q       <= in_b;
      target_q  <= in_target;
      pc_next_q <= in_pc_next;
    end
  end

  // Result registers; held until the next evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_taken <= 1'b0;
      out_pc    <= '0;
    end else if (eval_c) begin
      out_taken <= taken_c;
      out_pc    <= taken_c ? target_q : pc_next_q;
    end
  end

  // Saturating taken counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_count <= '0;
    end else if (clr_count) begin
      taken_count <= '0;
    end else if (eval_c && taken_c && (taken_count != '1)) begin
      taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule
